// File: rtl/vco_datapath_pkg.sv
// vco_datapath_pkg: shared widths, types and saturation helper for the multi-channel VCO-ADC datapath
package vco_datapath_pkg;
  localparam int N_CH_D     = 2;
  localparam int CNT_BITS_D = 9;
  localparam int DECIM_D    = 8;
  localparam int EXT_D      = 3;
  localparam int OUT_BITS_D = 9;
  localparam int DC_SHIFT_D = 6;
  function automatic int acc_w(input int cb, input int dec, input int ext);
    return cb + 1 + $clog2(dec) + ext;
  endfunction
  function automatic logic signed [63:0] out_max(input int ob);
    return (64'sd1 <<< (ob - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] out_min(input int ob);
    return -(64'sd1 <<< (ob - 1));
  endfunction
  typedef logic signed [CNT_BITS_D:0] diff_t;
  typedef logic signed [acc_w(CNT_BITS_D, DECIM_D, EXT_D)-1:0] acc_t;
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int ob);
    return v > out_max(ob) ? out_max(ob) : v < out_min(ob) ? out_min(ob) : v;
  endfunction
endpackage

// File: rtl/vco_datapath_lane.sv
// vco_datapath_lane: one channel -- prev registers, wrap-safe differences, frame accumulator, saturation
// Ports: i_clk clock; i_rst_n sync active-low reset; i_primed delta valid; i_frame last cycle of frame;
//        i_cnt_p/i_cnt_n extended counters; o_res saturated frame result (combinational, valid with i_frame).
// Optional DC blocker enabled by macro VCO_DATAPATH_DC_BLOCK_EN.
module vco_datapath_lane
  import vco_datapath_pkg::*;
#(
  parameter int CNT_BITS       = CNT_BITS_D,
  parameter int DECIM          = DECIM_D,
  parameter int N_BITS_ACC_EXT = EXT_D,
  parameter int OUT_BITS       = OUT_BITS_D,
  parameter int DC_SHIFT       = DC_SHIFT_D
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_primed,
  input  logic                i_frame,
  input  logic [CNT_BITS-1:0] i_cnt_p,
  input  logic [CNT_BITS-1:0] i_cnt_n,
  output logic [OUT_BITS-1:0] o_res
);
  localparam int AW = acc_w(CNT_BITS, DECIM, N_BITS_ACC_EXT);
  if (DECIM < 2 || DC_SHIFT < 1) begin : g_bad_cfg
    $error("vco_datapath_lane: DECIM must be >= 2 and DC_SHIFT >= 1");
  end
  logic [CNT_BITS-1:0] r_prev_p, r_prev_n, w_dp, w_dn;
  logic signed [CNT_BITS:0] w_d, w_dd;
  logic signed [AW-1:0] r_acc, w_sum;
  logic signed [63:0] w_pre;
  // modulo subtraction absorbs one counter wrap per cycle; deltas read as signed CNT_BITS values
  assign w_dp  = i_cnt_p - r_prev_p;
  assign w_dn  = i_cnt_n - r_prev_n;
  assign w_d   = $signed({w_dp[CNT_BITS-1], w_dp}) - $signed({w_dn[CNT_BITS-1], w_dn});
  // prev registers hold reset zeros in the unprimed cycle, so that delta is meaningless
  assign w_dd  = i_primed ? w_d : '0;
  assign w_sum = r_acc + AW'(w_dd);
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_prev_p <= '0;
      r_prev_n <= '0;
      r_acc    <= '0;
    end else begin
      r_prev_p <= i_cnt_p;
      r_prev_n <= i_cnt_n;
      r_acc    <= i_frame ? '0 : w_sum;
    end
`ifdef VCO_DATAPATH_DC_BLOCK_EN
  localparam int FW = AW + DC_SHIFT + 2;
  logic signed [FW-1:0] r_avg, w_err;
  // avg carries DC_SHIFT fractional bits; w_err is result-avg in the same fixed-point scale
  assign w_err = (FW'(w_sum) <<< DC_SHIFT) - r_avg;
  assign w_pre = 64'(w_err >>> DC_SHIFT);
  always_ff @(posedge i_clk)
    if (!i_rst_n) r_avg <= '0;
    else if (i_frame) r_avg <= r_avg + (w_err >>> DC_SHIFT);
`else
  assign w_pre = 64'(w_sum);
`endif
  assign o_res = OUT_BITS'(saturate(w_pre, OUT_BITS));
endmodule

// File: rtl/vco_adc_datapath_mc.sv
// vco_adc_datapath_mc: N_CH VCO-ADC lanes with internal decimation counter and valid/ready frame output
// Ports: CLK_24M clock; reset sync active-low; counter_p/counter_n packed per-channel counters;
//        channel_output packed signed frames; out_valid/out_ready handshake; overrun sticky; frame_phase debug.
// Optional DC blocker per lane enabled by macro VCO_DATAPATH_DC_BLOCK_EN.
module vco_adc_datapath_mc
  import vco_datapath_pkg::*;
#(
  parameter int N_CH           = N_CH_D,
  parameter int CNT_BITS       = CNT_BITS_D,
  parameter int DECIM          = DECIM_D,
  parameter int N_BITS_ACC_EXT = EXT_D,
  parameter int OUT_BITS       = OUT_BITS_D,
  parameter int DC_SHIFT       = DC_SHIFT_D
) (
  input  logic                      CLK_24M,
  input  logic                      reset,
  input  logic [N_CH*CNT_BITS-1:0]  counter_p,
  input  logic [N_CH*CNT_BITS-1:0]  counter_n,
  output logic [N_CH*OUT_BITS-1:0]  channel_output,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overrun,
  output logic [$clog2(DECIM)-1:0]  frame_phase
);
  localparam int PW = $clog2(DECIM);
  localparam logic [PW-1:0] LAST = PW'(DECIM - 1);
  logic [PW-1:0] r_phase;
  logic r_primed, r_valid, r_ovr, w_frame;
  logic [N_CH*OUT_BITS-1:0] r_out, w_res;
  assign w_frame = r_primed && (r_phase == LAST);
  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    vco_datapath_lane #(
      .CNT_BITS(CNT_BITS), .DECIM(DECIM), .N_BITS_ACC_EXT(N_BITS_ACC_EXT),
      .OUT_BITS(OUT_BITS), .DC_SHIFT(DC_SHIFT)
    ) u_lane (
      .i_clk    (CLK_24M),
      .i_rst_n  (reset),
      .i_primed (r_primed),
      .i_frame  (w_frame),
      .i_cnt_p  (counter_p[c*CNT_BITS +: CNT_BITS]),
      .i_cnt_n  (counter_n[c*CNT_BITS +: CNT_BITS]),
      .o_res    (w_res[c*OUT_BITS +: OUT_BITS])
    );
  end
  always_ff @(posedge CLK_24M)
    if (!reset) begin
      r_phase  <= '0;
      r_primed <= 1'b0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
      r_out    <= '0;
    end else begin
      r_primed <= 1'b1;
      if (r_primed) r_phase <= w_frame ? '0 : r_phase + PW'(1);
      // a new frame always wins; losing an unaccepted one is flagged sticky
      if (w_frame) begin
        r_out   <= w_res;
        r_valid <= 1'b1;
        if (r_valid && !out_ready) r_ovr <= 1'b1;
      end else if (r_valid && out_ready) r_valid <= 1'b0;
    end
  assign channel_output = r_out;
  assign out_valid      = r_valid;
  assign overrun        = r_ovr;
  assign frame_phase    = r_phase;
endmodule

// File: tb/tb_vco_adc_datapath_mc.sv
// tb_vco_adc_datapath_mc: randomized + directed self-checking bench against a frame-level model
module tb_vco_adc_datapath_mc;
  localparam int NC = 2, CB = 9, OB = 9, DEC = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, out_ready, out_valid, overrun;
  logic [NC*CB-1:0] counter_p, counter_n;
  logic [NC*OB-1:0] channel_output;
  logic [2:0] frame_phase;
  vco_adc_datapath_mc dut (
    .CLK_24M(clk), .reset(reset), .counter_p(counter_p), .counter_n(counter_n),
    .channel_output(channel_output), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .frame_phase(frame_phase)
  );
  int n_cmp = 0, n_bad = 0;
  int cp[NC], cn[NC], ip[NC], in_[NC];
  int m_n = -1;
  int m_lp[NC], m_ln[NC], m_acc[NC], m_out[NC];
  bit m_valid = 0, m_ovr = 0, chk_en = 0;
  function automatic int sx(input int v);
    int t;
    t = v & 511;
    return t >= 256 ? t - 512 : t;
  endfunction
  function automatic int sat(input int v);
    return v > 255 ? 255 : v < -256 ? -256 : v;
  endfunction
  function automatic int ch(input int c);
    logic signed [OB-1:0] t;
    t = channel_output[c*OB +: OB];
    return int'(t);
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // m_n = edges since reset release (0 = unprimed edge); frames close every DEC primed edges
  task automatic model_step(input bit rst_v, input bit rdy);
    bit fr;
    if (!rst_v) begin
      m_n = -1;
      for (int c = 0; c < NC; c++) begin m_acc[c] = 0; m_out[c] = 0; end
      m_valid = 0;
      m_ovr = 0;
    end else begin
      m_n++;
      fr = m_n >= 1 && m_n % DEC == 0;
      for (int c = 0; c < NC; c++)
        if (m_n >= 1) m_acc[c] += sx(cp[c] - m_lp[c]) - sx(cn[c] - m_ln[c]);
      if (fr) begin
        if (m_valid && !rdy) m_ovr = 1;
        m_valid = 1;
        for (int c = 0; c < NC; c++) begin m_out[c] = sat(m_acc[c]); m_acc[c] = 0; end
      end else if (m_valid && rdy) m_valid = 0;
    end
    for (int c = 0; c < NC; c++) begin m_lp[c] = cp[c]; m_ln[c] = cn[c]; end
  endtask
  task automatic tick(input bit rst_v, input bit rdy);
    #1;
    for (int c = 0; c < NC; c++) begin
      cp[c] = (cp[c] + ip[c]) & 511;
      cn[c] = (cn[c] + in_[c]) & 511;
      counter_p[c*CB +: CB] = cp[c][CB-1:0];
      counter_n[c*CB +: CB] = cn[c][CB-1:0];
    end
    reset = rst_v;
    out_ready = rdy;
    @(posedge clk);
    model_step(rst_v, rdy);
  endtask
  task automatic setup(input int base, input int incp, input int incn);
    for (int c = 0; c < NC; c++) begin cp[c] = base; cn[c] = base; ip[c] = incp; in_[c] = incn; end
    tick(0, 1);
  endtask
  always @(negedge clk)
    if (chk_en) begin
      for (int c = 0; c < NC; c++) chk($sformatf("model_ch%0d", c), ch(c), m_out[c]);
      chk("model_valid", out_valid, m_valid);
      chk("model_overrun", overrun, m_ovr);
      chk("model_phase", frame_phase, m_n < 0 ? 0 : m_n % DEC);
    end
  initial begin
    reset = 0; out_ready = 1; counter_p = '0; counter_n = '0;
    setup(0, 0, 0);
    tick(0, 1);
    chk_en = 1;
    @(negedge clk);
    chk("rst_out", int'(channel_output), 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_phase", frame_phase, 0);
    setup(100, 0, 0);
    repeat (9) tick(1, 1);
    @(negedge clk);
    chk("static_ch0", ch(0), 0);
    chk("static_ch1", ch(1), 0);
    chk("static_valid", out_valid, 1);
    repeat (15) tick(1, 1);
    setup(500, 5, 3);
    repeat (9) tick(1, 1);
    @(negedge clk);
    chk("offset_ch0", ch(0), 16);
    chk("offset_ch1", ch(1), 16);
    repeat (8) tick(1, 1);
    @(negedge clk);
    chk("offset2_ch0", ch(0), 16);
    chk("offset2_ch1", ch(1), 16);
    setup(7, 60, 0);
    repeat (9) tick(1, 1);
    @(negedge clk);
    chk("satpos_ch0", ch(0), 255);
    chk("satpos_ch1", ch(1), 255);
    setup(7, 0, 60);
    repeat (9) tick(1, 1);
    @(negedge clk);
    chk("satneg_ch0", ch(0), -256);
    chk("satneg_ch1", ch(1), -256);
    setup(50, 9, 2);
    repeat (25) tick(1, 0);
    @(negedge clk);
    chk("bp_ch0", ch(0), 56);
    chk("bp_valid", out_valid, 1);
    chk("bp_overrun", overrun, 1);
    tick(1, 1);
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_sticky_overrun", overrun, 1);
    setup(20, 4, 1);
    repeat (5) tick(1, 1);
    @(negedge clk);
    chk("mid_phase", frame_phase, 4);
    tick(0, 0);
    @(negedge clk);
    chk("mid_rst_out", int'(channel_output), 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_phase", frame_phase, 0);
    repeat (8) tick(1, 1);
    @(negedge clk);
    chk("mid_pre_frame_valid", out_valid, 0);
    tick(1, 1);
    @(negedge clk);
    chk("mid_frame_valid", out_valid, 1);
    chk("mid_frame_ch0", ch(0), 24);
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NC; c++) begin
        ip[c]  = ($urandom % 2 == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 255));
        in_[c] = ($urandom % 2 == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 255));
      end
      tick($urandom % 400 != 0, $urandom % 4 != 0);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
